mcdt_param: RTL and testbench

Parametrised multi-channel data transfer block. It is the successor to the fixed 3-channel mcdt.
- N slave channels, each with a valid/ready input and a buffering FIFO with margin report.
- Selectable round-robin or fixed-priority arbitration into one registered output port.
- New versus mcdt: output backpressure (mcdt_ready_i), per-channel enable, runtime arbitration mode.
- Driven by chnl_initiator-style masters; feeds downstream formatter/checker.

---
 rtl/mcdt_pkg.sv | 25 ++
 rtl/mcdt_param_if.sv | 36 +++
 rtl/mcdt_fifo.sv | 80 ++++++++
 rtl/mcdt_param.sv | 133 +++++++++++++
 tb/tb_mcdt_param.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mcdt_pkg.sv
// mcdt_pkg
// Shared types and defaults for the parametrised multi-channel data transfer
// block (mcdt_param), its channel FIFO (mcdt_fifo) and its bus interface
// (mcdt_param_if).
//   arb_mode_e : arbitration mode, round-robin or fixed priority
//   DEF_*      : default parameter values
//   id_width   : width of a channel id, never less than one bit
package mcdt_pkg;

   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   localparam int DEF_NUM_CH     = 3;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_FIFO_DEPTH = 32;

   // $clog2(2) is 1 but $clog2(1) would be 0, so clamp to keep the id
   // field a legal vector for any channel count.
   function automatic int id_width(input int num_ch);
      return (num_ch <= 2) ? 1 : $clog2(num_ch);
   endfunction

endpackage

// File: rtl/mcdt_param_if.sv
// mcdt_param_if
// Bundles the channel-side handshake and the downstream output port of
// mcdt_param.
//   master : the traffic source/sink (channel initiators plus the downstream
//            consumer); drives channel data/valid/enable, mode and ready
//   slave  : mcdt_param itself; drives channel ready/margin and output port
interface mcdt_param_if #(
   parameter int NUM_CH     = mcdt_pkg::DEF_NUM_CH,
   parameter int DATA_W     = mcdt_pkg::DEF_DATA_W,
   parameter int FIFO_DEPTH = mcdt_pkg::DEF_FIFO_DEPTH,
   parameter int MARGIN_W   = $clog2(FIFO_DEPTH + 1),
   parameter int ID_W       = mcdt_pkg::id_width(NUM_CH)
);

   logic [NUM_CH*DATA_W-1:0]   ch_data_i;
   logic [NUM_CH-1:0]          ch_valid_i;
   logic [NUM_CH-1:0]          ch_ready_o;
   logic [NUM_CH*MARGIN_W-1:0] ch_margin_o;
   logic [NUM_CH-1:0]          ch_en_i;
   logic                       arb_mode_i;
   logic [DATA_W-1:0]          mcdt_data_o;
   logic                       mcdt_val_o;
   logic [ID_W-1:0]            mcdt_id_o;
   logic                       mcdt_ready_i;

   modport master (
      output ch_data_i, ch_valid_i, ch_en_i, arb_mode_i, mcdt_ready_i,
      input  ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
   );

   modport slave (
      input  ch_data_i, ch_valid_i, ch_en_i, arb_mode_i, mcdt_ready_i,
      output ch_ready_o, ch_margin_o, mcdt_data_o, mcdt_val_o, mcdt_id_o
   );

endinterface

// File: rtl/mcdt_fifo.sv
// mcdt_fifo
// Synchronous single-clock FIFO of DATA_W x FIFO_DEPTH words. The depth need
// not be a power of two: both pointers wrap explicitly at FIFO_DEPTH-1.
// Read data is the word at the head, valid whenever empty_o is low.
//   clk_i, rst_i : clock, synchronous active-high reset (empties the FIFO)
//   push_i       : write wr_data_i (ignored when full)
//   pop_i        : discard the head word (ignored when empty)
//   rd_data_o    : head word
//   full_o       : FIFO_DEPTH words stored
//   empty_o      : no words stored
//   count_o      : number of stored words
module mcdt_fifo #(
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 32,
   parameter int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              do_push;
   logic              do_pop;

   // Advance a pointer, wrapping at the last real slot rather than at the
   // next power of two.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o    = (count == CNT_W'(FIFO_DEPTH));
   assign empty_o   = (count == '0);
   assign count_o   = count;
   assign rd_data_o = mem[rd_ptr];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   // Storage array has no reset; only the pointers and count decide which
   // entries are meaningful, so stale contents after reset are harmless.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem[wr_ptr] <= wr_data_i;
      end
   end

   // Pointer and occupancy bookkeeping. A simultaneous push and pop moves
   // both pointers and leaves the count unchanged.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/mcdt_param.sv
// mcdt_param
// Parametrised multi-channel data transfer block. Each of NUM_CH channels
// feeds its own FIFO; an arbiter (round-robin or fixed priority, chosen at
// runtime) moves one word per cycle from a non-empty FIFO into a single
// registered output slot that honours downstream backpressure.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : ch_data_i/ch_valid_i/ch_ready_o  per-channel write port
//                  ch_margin_o                     free words per channel
//                  ch_en_i                         per-channel input enable
//                  arb_mode_i                      0 round-robin, 1 fixed
//                  mcdt_data_o/val_o/id_o/ready_i  output port
module mcdt_param
   import mcdt_pkg::*;
#(
   parameter int NUM_CH     = DEF_NUM_CH,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int MARGIN_W   = $clog2(FIFO_DEPTH + 1),
   parameter int ID_W       = id_width(NUM_CH)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   mcdt_param_if.slave  bus
);

   logic [NUM_CH-1:0]   ch_ready;
   logic [NUM_CH-1:0]   push;
   logic [NUM_CH-1:0]   pop;
   logic [NUM_CH-1:0]   full;
   logic [NUM_CH-1:0]   empty;
   logic [MARGIN_W-1:0] count   [NUM_CH];
   logic [DATA_W-1:0]   rd_data [NUM_CH];

   logic                out_val;
   logic [DATA_W-1:0]   out_data;
   logic [ID_W-1:0]     out_id;
   logic [ID_W-1:0]     rr_ptr;

   logic                slot_load;
   logic                grant_val;
   logic [ID_W-1:0]     grant_id;
   logic [DATA_W-1:0]   grant_data;
   int                  rr_idx;
   arb_mode_e           arb_mode;

   assign arb_mode  = arb_mode_e'(bus.arb_mode_i);

   // The slot may take a new word when it is empty or when its current
   // word leaves this very cycle, which sustains one word per cycle.
   assign slot_load = !out_val || bus.mcdt_ready_i;

   // Per-channel input side: ready depends only on enable, occupancy and
   // reset (never on valid), and the margin reads full depth during reset.
   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign ch_ready[c] = bus.ch_en_i[c] && !full[c] && !rst_i;
      assign push[c]     = bus.ch_valid_i[c] && ch_ready[c];
      assign pop[c]      = slot_load && grant_val && (grant_id == ID_W'(c));
      assign bus.ch_margin_o[c*MARGIN_W +: MARGIN_W] =
         rst_i ? MARGIN_W'(FIFO_DEPTH) : MARGIN_W'(FIFO_DEPTH) - count[c];

      mcdt_fifo #(
         .DATA_W     (DATA_W),
         .FIFO_DEPTH (FIFO_DEPTH),
         .CNT_W      (MARGIN_W)
      ) u_fifo (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .push_i     (push[c]),
         .wr_data_i  (bus.ch_data_i[c*DATA_W +: DATA_W]),
         .pop_i      (pop[c]),
         .rd_data_o  (rd_data[c]),
         .full_o     (full[c]),
         .empty_o    (empty[c]),
         .count_o    (count[c])
      );
   end

   assign bus.ch_ready_o = ch_ready;

   // Arbiter. Both searches walk candidates from lowest to highest priority
   // so the last hit assigned is the winner. Fixed priority favours the
   // lowest index; round-robin starts just after the last granted channel
   // and wraps, so the last granted channel itself is considered last.
   always_comb begin
      grant_val  = 1'b0;
      grant_id   = '0;
      grant_data = '0;
      rr_idx     = 0;
      if (arb_mode == ARB_FIXED) begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (!empty[i]) begin
               grant_val  = 1'b1;
               grant_id   = ID_W'(i);
               grant_data = rd_data[i];
            end
         end
      end else begin
         for (int i = NUM_CH; i >= 1; i--) begin
            rr_idx = (int'(rr_ptr) + i) % NUM_CH;
            if (!empty[rr_idx]) begin
               grant_val  = 1'b1;
               grant_id   = ID_W'(rr_idx);
               grant_data = rd_data[rr_idx];
            end
         end
      end
   end

   // Output slot and round-robin pointer. The pointer tracks every grant in
   // either mode so switching back to round-robin continues fairly. When the
   // slot drains with nothing granted, data and id keep their last values
   // but valid drops.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_val  <= 1'b0;
         out_data <= '0;
         out_id   <= '0;
         rr_ptr   <= ID_W'(NUM_CH - 1);
      end else if (slot_load) begin
         out_val <= grant_val;
         if (grant_val) begin
            out_data <= grant_data;
            out_id   <= grant_id;
            rr_ptr   <= grant_id;
         end
      end
   end

   assign bus.mcdt_val_o  = out_val;
   assign bus.mcdt_data_o = out_data;
   assign bus.mcdt_id_o   = out_id;

endmodule

// File: tb/tb_mcdt_param.sv
// tb_mcdt_param
// Randomised self-checking bench for mcdt_param. A queue-based reference
// model (per-channel word queues plus one output slot) predicts ready,
// margins, output valid and the word each grant delivers; predicted output
// words go into a scoreboard queue that a separate monitor drains whenever
// the DUT hands a word downstream.
module tb_mcdt_param;
   import mcdt_pkg::*;

   localparam int NUM_CH     = 3;
   localparam int DATA_W     = 32;
   localparam int FIFO_DEPTH = 32;
   localparam int MARGIN_W   = $clog2(FIFO_DEPTH + 1);
   localparam int ID_W       = id_width(NUM_CH);

   typedef struct {
      int                id;
      logic [DATA_W-1:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst;

   mcdt_param_if #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
      .MARGIN_W(MARGIN_W), .ID_W(ID_W)
   ) bus ();

   mcdt_param #(
      .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH),
      .MARGIN_W(MARGIN_W), .ID_W(ID_W)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [DATA_W-1:0] model_q [NUM_CH][$];
   int                model_ptr;
   bit                model_slot_v;
   exp_t              exp_q[$];
   exp_t              mon_e;

   logic [DATA_W-1:0] drv_data [NUM_CH];
   int                drv_n    [NUM_CH];
   bit                accepted [NUM_CH];

   int checks_total  = 0;
   int checks_passed = 0;
   int cycle_count   = 0;

   // One comparison: counts it and reports a failure with both values.
   task automatic checkOutput(input string name, input longint act, input longint exp);
      checks_total++;
      if (act == exp) checks_passed++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle_count);
   endtask

   function automatic int margin_of(input int c);
      return int'(bus.ch_margin_o[c*MARGIN_W +: MARGIN_W]);
   endfunction

   // Restart every channel's data counter at word 0.
   task automatic resetDriver();
      for (int c = 0; c < NUM_CH; c++) begin
         drv_n[c]    = 0;
         drv_data[c] = 32'h00C0_0000 + DATA_W'(c << 16);
      end
   endtask

   // Drive one cycle of inputs, step the reference model across the coming
   // edge, then compare the DUT state just after that edge.
   task automatic applyStimulus(input bit rst_v, input logic [NUM_CH-1:0] valid_v,
                                input logic [NUM_CH-1:0] en_v, input bit mode_v,
                                input bit ready_v);
      logic [NUM_CH-1:0] m_ready;
      int                g;
      int                cand;
      bit                found;
      logic [DATA_W-1:0] w;
      rst              = rst_v;
      bus.ch_valid_i   = valid_v;
      bus.ch_en_i      = en_v;
      bus.arb_mode_i   = mode_v;
      bus.mcdt_ready_i = ready_v;
      for (int c = 0; c < NUM_CH; c++) bus.ch_data_i[c*DATA_W +: DATA_W] = drv_data[c];
      #1;
      m_ready = '0;
      for (int c = 0; c < NUM_CH; c++) accepted[c] = 1'b0;
      if (rst_v) begin
         checkOutput("ready_in_reset", bus.ch_ready_o, 0);
         for (int c = 0; c < NUM_CH; c++) checkOutput("margin_in_reset", margin_of(c), FIFO_DEPTH);
         for (int c = 0; c < NUM_CH; c++) model_q[c].delete();
         exp_q.delete();
         model_slot_v = 1'b0;
         model_ptr    = NUM_CH - 1;
      end else begin
         for (int c = 0; c < NUM_CH; c++) m_ready[c] = en_v[c] && (model_q[c].size() < FIFO_DEPTH);
         checkOutput("ch_ready", bus.ch_ready_o, m_ready);
         if (!model_slot_v || ready_v) begin
            found = 1'b0;
            g     = 0;
            for (int k = 1; k <= NUM_CH; k++) begin
               cand = mode_v ? (k - 1) : ((model_ptr + k) % NUM_CH);
               if (!found && model_q[cand].size() > 0) begin
                  found = 1'b1;
                  g     = cand;
               end
            end
            if (found) begin
               w = model_q[g].pop_front();
               exp_q.push_back('{id: g, data: w});
               model_ptr    = g;
               model_slot_v = 1'b1;
            end else begin
               model_slot_v = 1'b0;
            end
         end
         for (int c = 0; c < NUM_CH; c++) begin
            if (valid_v[c] && m_ready[c]) begin
               model_q[c].push_back(drv_data[c]);
               accepted[c] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      cycle_count++;
      checkOutput("mcdt_val", bus.mcdt_val_o, model_slot_v);
      if (model_slot_v && exp_q.size() > 0) begin
         checkOutput("slot_data", bus.mcdt_data_o, exp_q[0].data);
         checkOutput("slot_id", bus.mcdt_id_o, exp_q[0].id);
      end
      for (int c = 0; c < NUM_CH; c++) checkOutput("margin", margin_of(c), FIFO_DEPTH - model_q[c].size());
      for (int c = 0; c < NUM_CH; c++) begin
         if (accepted[c]) begin
            drv_n[c]++;
            drv_data[c] = 32'h00C0_0000 + DATA_W'(c << 16) + DATA_W'(drv_n[c]);
         end
      end
   endtask

   // Run with inputs idle and downstream ready until the model is empty.
   task automatic drain(input logic [NUM_CH-1:0] en_v, input bit mode_v);
      int budget = 0;
      while ((exp_q.size() > 0 || model_slot_v ||
              model_q[0].size() + model_q[1].size() + model_q[2].size() > 0) && budget < 400) begin
         applyStimulus(1'b0, '0, en_v, mode_v, 1'b1);
         budget++;
      end
      checkOutput("drain_timeout", budget >= 400, 0);
   endtask

   // Scoreboard monitor: a word leaves the DUT at the next edge whenever
   // valid and ready are both high mid-cycle outside reset.
   always @(negedge clk) begin
      if (rst == 1'b0 && bus.mcdt_val_o == 1'b1 && bus.mcdt_ready_i == 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_output", bus.mcdt_data_o, 0);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput("out_data", bus.mcdt_data_o, mon_e.data);
            checkOutput("out_id", bus.mcdt_id_o, mon_e.id);
         end
      end
   end

   // Directed scenarios followed by a randomised soak.
   initial begin
      int guard;
      logic [NUM_CH-1:0] v;
      bit mode;
      rst = 1'b1;
      model_ptr    = NUM_CH - 1;
      model_slot_v = 1'b0;
      resetDriver();

      $display("[TB] reset");
      repeat (10) applyStimulus(1'b1, '0, 3'b111, 1'b0, 1'b0);
      checkOutput("reset_data", bus.mcdt_data_o, 0);
      checkOutput("reset_id", bus.mcdt_id_o, 0);
      applyStimulus(1'b0, '0, 3'b111, 1'b0, 1'b1);
      checkOutput("ready_after_reset", bus.ch_ready_o, 3'b111);

      $display("[TB] single channel stream");
      resetDriver();
      guard = 0;
      while (drv_n[0] < 100 && guard < 300) begin
         applyStimulus(1'b0, 3'b001, 3'b111, 1'b0, 1'b1);
         guard++;
      end
      checkOutput("stream_accepts", drv_n[0], 100);
      drain(3'b111, 1'b0);

      $display("[TB] round robin");
      resetDriver();
      repeat (60) applyStimulus(1'b0, 3'b111, 3'b111, 1'b0, 1'b1);
      drain(3'b111, 1'b0);

      $display("[TB] fixed priority");
      repeat (2) applyStimulus(1'b1, '0, 3'b111, 1'b0, 1'b0);
      resetDriver();
      guard = 0;
      while ((drv_n[0] < 4 || drv_n[1] < 4 || drv_n[2] < 4) && guard < 50) begin
         for (int c = 0; c < NUM_CH; c++) v[c] = (drv_n[c] < 4);
         applyStimulus(1'b0, v, 3'b111, 1'b0, 1'b0);
         guard++;
      end
      checkOutput("held_word", bus.mcdt_data_o, 32'h00C0_0000);
      drain(3'b111, 1'b1);

      $display("[TB] backpressure");
      repeat (2) applyStimulus(1'b1, '0, 3'b111, 1'b0, 1'b0);
      resetDriver();
      repeat (40) applyStimulus(1'b0, 3'b001, 3'b111, 1'b0, 1'b0);
      checkOutput("bp_accepts", drv_n[0], 33);
      checkOutput("bp_margin0", margin_of(0), 0);
      drain(3'b111, 1'b0);

      $display("[TB] enable and mid-transfer reset");
      resetDriver();
      repeat (10) applyStimulus(1'b0, 3'b111, 3'b111, 1'b0, 1'b0);
      repeat (15) applyStimulus(1'b0, 3'b111, 3'b101, 1'b0, 1'b1);
      repeat (5) applyStimulus(1'b0, 3'b111, 3'b111, 1'b0, 1'b1);
      applyStimulus(1'b1, 3'b111, 3'b111, 1'b0, 1'b1);
      checkOutput("val_after_reset", bus.mcdt_val_o, 0);
      resetDriver();
      repeat (20) applyStimulus(1'b0, 3'b111, 3'b111, 1'b0, 1'b1);
      drain(3'b111, 1'b0);

      $display("[TB] random soak");
      mode = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) mode = ~mode;
         applyStimulus($urandom_range(0, 199) == 0, NUM_CH'($urandom),
                       NUM_CH'($urandom | $urandom), mode,
                       $urandom_range(0, 3) != 0);
      end
      drain(3'b111, 1'b0);

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule
